// File: rtl/aibnd_bsr_red_pkg.sv
// Shared types and constants for the AIB redundancy / boundary-scan chain.
// Used by both the default and the AIBND_BSR_RED_LPBK_EN builds.
package aibnd_bsr_red_pkg;

    localparam int CELL_TX       = 0;
    localparam int CELL_RX       = 1;
    localparam int CELLS_PER_PAD = 2;
    localparam int RED_IDX_MAXW  = 8;

    typedef struct packed {
        logic                    vld;
        logic [RED_IDX_MAXW-1:0] idx;
    } red_map_t;

    function automatic int red_idxw(input int nch);
        return $clog2(nch + 2);
    endfunction

endpackage

// File: rtl/aibnd_bsr_red_chain_if.sv
// Data bus between the HSSI adapter, this block and the AIB pad buffers.
// slave = the redundancy block; master = whatever sits on the other side.
interface aibnd_bsr_red_chain_if #(
    parameter int NCH = 8
);
    logic [NCH-1:0] adap_tx_dat;
    logic [NCH:0]   aib_tx_dat;
    logic [NCH:0]   aib_rx_dat;
    logic [NCH-1:0] adap_rx_dat;

    modport slave  (input adap_tx_dat, input aib_rx_dat, output aib_tx_dat, output adap_rx_dat);
    modport master (output adap_tx_dat, output aib_rx_dat, input aib_tx_dat, input adap_rx_dat);
endinterface

// File: rtl/aibnd_bsr_red_cell.sv
// One pad's boundary-scan slice: TX and RX scan flops plus their update flops.
// Priority per edge is capture > shift > hold; update copies the pre-edge scan value.
module aibnd_bsr_red_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic tx_cap,
    input  logic rx_cap,
    input  logic tx_sin,
    input  logic rx_sin,
    output logic tx_scan_q,
    output logic rx_scan_q,
    output logic tx_upd_q,
    output logic rx_upd_q
);
    logic tx_scan_d, rx_scan_d, tx_upd_d, rx_upd_d;

    always_comb begin
        tx_scan_d = tx_scan_q;
        rx_scan_d = rx_scan_q;
        tx_upd_d  = tx_upd_q;
        rx_upd_d  = rx_upd_q;
        if (capture) begin
            tx_scan_d = tx_cap;
            rx_scan_d = rx_cap;
        end else if (shift) begin
            tx_scan_d = tx_sin;
            rx_scan_d = rx_sin;
        end
        if (update) begin
            tx_upd_d = tx_scan_q;
            rx_upd_d = rx_scan_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_scan_q <= 1'b0;
            rx_scan_q <= 1'b0;
            tx_upd_q  <= 1'b0;
            rx_upd_q  <= 1'b0;
        end else begin
            tx_scan_q <= tx_scan_d;
            rx_scan_q <= rx_scan_d;
            tx_upd_q  <= tx_upd_d;
            rx_upd_q  <= rx_upd_d;
        end
    end
endmodule

// File: rtl/aibnd_bsr_red_chain.sv
// NCH logical channels over NCH+1 AIB pads with a programmable spare-pad repair map
// and a full boundary-scan chain. Define AIBND_BSR_RED_LPBK_EN for update-TX loopback capture.
module aibnd_bsr_red_chain
    import aibnd_bsr_red_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int IDXW = red_idxw(NCH)
) (
    input  logic            jtag_clkdr_in,
    input  logic            jtag_rstb,
    aibnd_bsr_red_chain_if.slave dif,
    input  logic            red_load,
    input  logic            red_fail_vld,
    input  logic [IDXW-1:0] red_fail_idx,
    output logic            red_cfg_err,
    input  logic            jtag_mode_in,
    input  logic            jtag_tx_scanen_in,
    input  logic            jtag_capture,
    input  logic            jtag_update,
    input  logic            jtag_tx_scan_in,
`ifdef AIBND_BSR_RED_LPBK_EN
    input  logic            jtag_loopbacken_in,
`endif
    output logic            jtag_tx_scan_out
);
    localparam int NPAD = NCH + 1;
    localparam int NB   = CELLS_PER_PAD * NPAD;

    red_map_t map_q, map_d;
    logic     err_q, err_d;

    logic [NPAD-1:0] tx_ext, func_tx, upd_tx, upd_rx, rx_src, cap_rx;
    logic [NB-1:0]   scan_vec, upd_vec, shift_src;
    int              fidx;

    // Loads during JTAG mode are dropped so a scan session cannot disturb the repair.
    always_comb begin
        map_d = map_q;
        err_d = err_q;
        if (red_load && !jtag_mode_in) begin
            if (int'(red_fail_idx) <= NCH) begin
                map_d.vld = red_fail_vld;
                map_d.idx = RED_IDX_MAXW'(red_fail_idx);
                err_d     = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge jtag_clkdr_in or negedge jtag_rstb) begin
        if (!jtag_rstb) begin
            map_q <= '0;
            err_q <= 1'b0;
        end else begin
            map_q <= map_d;
            err_q <= err_d;
        end
    end

    assign red_cfg_err = err_q;
    assign fidx        = int'(map_q.idx);
    assign tx_ext      = {1'b0, dif.adap_tx_dat};

    always_comb begin
        func_tx = '0;
        upd_tx  = '0;
        upd_rx  = '0;
        for (int p = 0; p < NPAD; p++) begin
            upd_tx[p] = upd_vec[CELLS_PER_PAD*p + CELL_TX];
            upd_rx[p] = upd_vec[CELLS_PER_PAD*p + CELL_RX];
            if (!map_q.vld || p < fidx) begin
                func_tx[p] = tx_ext[p];
            end else if (p > fidx) begin
                func_tx[p] = tx_ext[p-1];
            end
        end
    end

    assign dif.aib_tx_dat = jtag_mode_in ? upd_tx : func_tx;
    assign rx_src         = jtag_mode_in ? upd_rx : dif.aib_rx_dat;

    always_comb begin
        dif.adap_rx_dat = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!map_q.vld || c < fidx) dif.adap_rx_dat[c] = rx_src[c];
            else                        dif.adap_rx_dat[c] = rx_src[c+1];
        end
    end

`ifdef AIBND_BSR_RED_LPBK_EN
    assign cap_rx = (jtag_mode_in && jtag_loopbacken_in) ? upd_tx : dif.aib_rx_dat;
`else
    assign cap_rx = dif.aib_rx_dat;
`endif

    // Chain shifts toward bit 0; scan-in enters at the top RX cell.
    assign shift_src        = {jtag_tx_scan_in, scan_vec[NB-1:1]};
    assign jtag_tx_scan_out = scan_vec[0];

    for (genvar p = 0; p < NPAD; p++) begin : g_pad
        aibnd_bsr_red_cell u_cell (
            .clk       (jtag_clkdr_in),
            .rst_n     (jtag_rstb),
            .capture   (jtag_capture),
            .shift     (jtag_tx_scanen_in),
            .update    (jtag_update),
            .tx_cap    (func_tx[p]),
            .rx_cap    (cap_rx[p]),
            .tx_sin    (shift_src[CELLS_PER_PAD*p + CELL_TX]),
            .rx_sin    (shift_src[CELLS_PER_PAD*p + CELL_RX]),
            .tx_scan_q (scan_vec[CELLS_PER_PAD*p + CELL_TX]),
            .rx_scan_q (scan_vec[CELLS_PER_PAD*p + CELL_RX]),
            .tx_upd_q  (upd_vec[CELLS_PER_PAD*p + CELL_TX]),
            .rx_upd_q  (upd_vec[CELLS_PER_PAD*p + CELL_RX])
        );
    end
endmodule
